// File: rtl/tmr_vote_monitor_if.sv
// tmr_vote_monitor_if: bundle of the triplicated-input, voted-output and health-status signals
// Ports (master drives / slave receives):
//   in_valid, in_a, in_b, in_c, clr            master -> slave  redundant copies, sample strobe, status clear
//   data_out, out_valid                        slave -> master  registered majority word and its strobe
//   err_a, err_b, err_c, multi_err, err_cnt    slave -> master  sticky fault flags and saturating mismatch count
//   state                                      slave -> master  health FSM (0 OK, 1 SUSPECT, 2 FAULT, 3 FAIL)
interface tmr_vote_monitor_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic             clr;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             err_a;
    logic             err_b;
    logic             err_c;
    logic             multi_err;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       state;

    modport master (
        output in_valid, in_a, in_b, in_c, clr,
        input  data_out, out_valid, err_a, err_b, err_c, multi_err, err_cnt, state
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, clr,
        output data_out, out_valid, err_a, err_b, err_c, multi_err, err_cnt, state
    );
endinterface

// File: rtl/tmr_vote_monitor.sv
// tmr_vote_monitor: majority voter for a triplicated bus with per-copy fault tracking and health FSM
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    tmr_vote_monitor_if.slave: in_valid/in_a/in_b/in_c/clr in; data_out/out_valid,
//          err_a/err_b/err_c/multi_err, err_cnt, state out
module tmr_vote_monitor #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8,
    parameter int PERSIST = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    tmr_vote_monitor_if.slave  bus
);
    localparam logic [3:0] PMAX = 4'(PERSIST);

    typedef enum logic [1:0] {S_OK, S_SUSPECT, S_FAULT, S_FAIL} state_t;

    logic [WIDTH-1:0] maj;
    logic [2:0]       mis;
    logic [1:0]       nmis;
    logic [1:0]       nerr;
    logic             count;

    logic [WIDTH-1:0] data_out_d, data_out_q;
    logic             out_valid_d, out_valid_q;
    logic [2:0]       err_d, err_q;
    logic             multi_d, multi_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [3:0]       pers_d [3];
    logic [3:0]       pers_q [3];
    state_t           state_d, state_q;

    always_comb begin
        maj   = (bus.in_a & bus.in_b) | (bus.in_a & bus.in_c) | (bus.in_b & bus.in_c);
        mis   = {|(bus.in_c ^ maj), |(bus.in_b ^ maj), |(bus.in_a ^ maj)};
        nmis  = {1'b0, mis[0]} + {1'b0, mis[1]} + {1'b0, mis[2]};
        // a sample coinciding with clr is still voted but never scored
        count = bus.in_valid && !bus.clr;
        data_out_d  = bus.in_valid ? maj : data_out_q;
        out_valid_d = bus.in_valid;
        for (int i = 0; i < 3; i++) begin
            pers_d[i] = pers_q[i];
            err_d[i]  = err_q[i];
            if (bus.clr) begin
                pers_d[i] = 4'd0;
                err_d[i]  = 1'b0;
            end else if (count) begin
                pers_d[i] = !mis[i] ? 4'd0 : (pers_q[i] >= PMAX) ? PMAX : pers_q[i] + 4'd1;
                err_d[i]  = err_q[i] | (mis[i] && pers_d[i] == PMAX);
            end
        end
        multi_d = !bus.clr && (multi_q || (count && nmis >= 2'd2));
        cnt_d   = bus.clr ? '0 : (count && nmis != 2'd0 && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        nerr    = {1'b0, err_d[0]} + {1'b0, err_d[1]} + {1'b0, err_d[2]};
    end

    // health FSM sees the flags as they will be after this update
    always_comb begin
        state_d = state_q;
        if (bus.clr)
            state_d = S_OK;
        else if (nerr >= 2'd2 || multi_d)
            state_d = S_FAIL;
        else if (state_q == S_FAIL || state_q == S_FAULT)
            state_d = state_q;
        else if (nerr == 2'd1)
            state_d = S_FAULT;
        else if (state_q == S_OK && count && nmis == 2'd1)
            state_d = S_SUSPECT;
        else if (state_q == S_SUSPECT && count && nmis == 2'd0)
            state_d = S_OK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= '0;
            multi_q     <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_OK;
            for (int i = 0; i < 3; i++) pers_q[i] <= 4'd0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            multi_q     <= multi_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            for (int i = 0; i < 3; i++) pers_q[i] <= pers_d[i];
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_a     = err_q[0];
    assign bus.err_b     = err_q[1];
    assign bus.err_c     = err_q[2];
    assign bus.multi_err = multi_q;
    assign bus.err_cnt   = cnt_q;
    assign bus.state     = state_q;
endmodule

// File: doc/tmr_vote_monitor.md
Name: tmr_vote_monitor

Overview:
- Consumer side of a triplicated signal path. Receives the three redundant copies of a WIDTH-bit bus produced by triplicated logic.
- Outputs a registered majority-voted word and tracks per-copy disagreement over time.
- Reports sticky fault flags, a saturating error count and a 4-state health FSM.
- Sits at the boundary where triplicated logic feeds non-triplicated logic or status registers.

Parameters:
- WIDTH, 8, width of each redundant copy and of the voted output.
- CNT_W, 8, width of the saturating mismatch-event counter.
- PERSIST, 3, consecutive mismatching valid samples on one copy before that copy is declared faulty (legal range 1..15).

Ports:
- clk  input  1  single clock, all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  the three copies carry a sample this cycle.
- in_a  input  WIDTH  copy A.
- in_b  input  WIDTH  copy B.
- in_c  input  WIDTH  copy C.
- clr  input  1  synchronous clear of all health status.
- data_out  output  WIDTH  registered bitwise majority of in_a/in_b/in_c.
- out_valid  output  1  data_out updated this cycle.
- err_a  output  1  sticky: copy A faulty.
- err_b  output  1  sticky: copy B faulty.
- err_c  output  1  sticky: copy C faulty.
- multi_err  output  1  sticky: two or more copies disagreed with the majority in one sample.
- err_cnt  output  CNT_W  count of valid samples with any mismatch, saturating.
- state  output  2  health FSM: 0 OK, 1 SUSPECT, 2 FAULT, 3 FAIL.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-sample): data_out=0, out_valid=0, err_a/b/c=0, multi_err=0, err_cnt=0, state=OK, persistence counters=0. Release is synchronous to clk.
- Vote: maj = (a&b)|(a&c)|(b&c), bitwise.
  - When in_valid=1: data_out<=maj. Latency 1 cycle.
  - out_valid<=in_valid every cycle. When in_valid=0, data_out holds.
- Mismatch per valid sample: mis_x = |(in_x ^ maj) for x in a, b, c. nmis = number of mis_x set.
- Persistence counter per copy (4 bits), updated on valid samples only:
  - mis_x=1: increment, saturating at PERSIST.
  - mis_x=0: reset to 0.
  - in_valid=0 cycles do not break a run.
  - When the counter reaches PERSIST, err_x<=1 in the same update.
- multi_err<=1 on any valid sample with nmis>=2.
- err_cnt increments by 1 on each valid sample with nmis>=1, and holds at 2^CNT_W-1.
- FSM, evaluated on the updated flags; priority top-down:
  - Any state -> FAIL: two or more err_x set, or multi_err set.
  - OK/SUSPECT -> FAULT: exactly one err_x set.
  - OK -> SUSPECT: valid sample with nmis=1.
  - SUSPECT -> OK: valid sample with nmis=0 while no err_x is set.
  - FAULT holds until FAIL or clr.
  - FAIL is terminal until clr or reset.
- Voting is unaffected by health status: the majority is output in every state.
- clr=1: next cycle err_a/b/c=0, multi_err=0, err_cnt=0, persistence counters=0, state=OK.
- clr and in_valid in the same cycle: the sample is voted and output normally, but its mismatches are not counted and status is cleared.

Test Plan:
- Pulse rst_n low for 1 cycle mid-stream while in_valid=1, in_a/b/c=0xFF -> all outputs 0 and state=0 immediately; out_valid stays 0 until the next valid sample after release.
- in_a=in_b=in_c=0xA5, in_valid=1 for one cycle -> next cycle data_out=0xA5, out_valid=1, no flags, err_cnt=0, state=OK.
- in_b=0x25, a=c=0xA5 for 2 valid samples, then a clean sample -> data_out=0xA5 each time; state OK->SUSPECT->SUSPECT->OK; err_b=0; err_cnt=2.
- in_b corrupted on 3 valid samples with 2 idle cycles between them (PERSIST=3) -> err_b=1 after the 3rd sample, state=FAULT, err_cnt=3. Then in_c corrupted for 3 samples -> err_c=1, state=FAIL.
- a=0x01, b=0x02, c=0x00, one valid sample -> data_out=0x00, multi_err=1, state=FAIL, err_cnt=1. Then clr=1 with a clean sample -> data_out updated, all flags 0, err_cnt=0, state=OK.
- CNT_W=2, 5 consecutive mismatched valid samples on copy A -> err_cnt=3 (saturated), no wrap to 0.
